// File: rtl/alu_16bit_pkg.sv
// Shared constants for the ALU issuer: op-codes, FSM states, response flag bit positions.
package alu_16bit_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Bit positions inside rsp_flags = {carry, zero, overflow, negative}
  localparam int CARRY = 3;
  localparam int ZERO  = 2;
  localparam int OVF   = 1;
  localparam int NEG   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SAMPLE = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_16bit_issuer_if.sv
// Command, ALU-drive and response bundle between the issuer and its environment.
interface alu_16bit_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [1:0]  cmd_op;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_negative;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_mismatch;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_result, alu_carry, alu_zero, alu_overflow, alu_negative,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_flags, rsp_mismatch
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_result, alu_carry, alu_zero, alu_overflow, alu_negative,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_flags, rsp_mismatch
  );
endinterface

// File: rtl/alu_16bit_ref_model.sv
// Combinational golden model of the 16-bit ALU: result plus carry/zero/overflow/negative.
module alu_16bit_ref_model
  import alu_16bit_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  op,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero,
  output logic        overflow,
  output logic        negative
);

  logic [16:0] sum_w;
  logic [16:0] diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum_w[15:0];
        carry    = sum_w[16];
        overflow = (a[15] == b[15]) && (sum_w[15] != a[15]);
      end
      OP_SUB: begin
        // bit16 of the 17-bit difference is the borrow-style carry
        result   = diff_w[15:0];
        carry    = diff_w[16];
        overflow = (a[15] != b[15]) && (diff_w[15] != a[15]);
      end
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
    zero     = (result == 16'h0000);
    negative = result[15];
  end

endmodule

// File: rtl/alu_16bit_issuer.sv
// Issues one command at a time to an external registered ALU, captures its response and
// checks it against the golden model, counting mismatches in a saturating counter.
module alu_16bit_issuer
  import alu_16bit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_clr,
  alu_16bit_issuer_if.slave    bus,
  output logic [CNT_W-1:0]     mismatch_count
);

  state_e             state_q, state_d;
  logic [15:0]        alu_a_q, alu_a_d;
  logic [15:0]        alu_b_q, alu_b_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic [15:0]        lat_a_q, lat_a_d;
  logic [15:0]        lat_b_q, lat_b_d;
  logic [1:0]         lat_op_q, lat_op_d;
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_mismatch_q, rsp_mismatch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        ref_result;
  logic               ref_carry, ref_zero, ref_ovf, ref_neg;
  logic [3:0]         ref_flags;
  logic [3:0]         alu_flags;
  logic               mismatch;
  logic               accept;

  alu_16bit_ref_model u_ref (
    .a        (lat_a_q),
    .b        (lat_b_q),
    .op       (lat_op_q),
    .result   (ref_result),
    .carry    (ref_carry),
    .zero     (ref_zero),
    .overflow (ref_ovf),
    .negative (ref_neg)
  );

  assign ref_flags = {ref_carry, ref_zero, ref_ovf, ref_neg};
  assign alu_flags = {bus.alu_carry, bus.alu_zero, bus.alu_overflow, bus.alu_negative};
  assign mismatch  = (bus.alu_result != ref_result) || (alu_flags != ref_flags);

  // Handshake outputs are gated by rst_n so they drop as soon as reset is asserted
  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = rst_n && (state_q == RESP);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    lat_a_d        = lat_a_q;
    lat_b_d        = lat_b_q;
    lat_op_d       = lat_op_q;
    rsp_result_d   = rsp_result_q;
    rsp_flags_d    = rsp_flags_q;
    rsp_mismatch_d = rsp_mismatch_q;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
          lat_a_d  = bus.cmd_a;
          lat_b_d  = bus.cmd_b;
          lat_op_d = bus.cmd_op;
          state_d  = EXEC;
        end
      end
      EXEC:   state_d = SAMPLE;
      SAMPLE: begin
        rsp_result_d   = bus.alu_result;
        rsp_flags_d    = alu_flags;
        rsp_mismatch_d = mismatch;
        if (mismatch && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over an increment landing on the same edge
    if (cnt_clr)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      lat_a_q        <= '0;
      lat_b_q        <= '0;
      lat_op_q       <= '0;
      rsp_result_q   <= '0;
      rsp_flags_q    <= '0;
      rsp_mismatch_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      lat_a_q        <= lat_a_d;
      lat_b_q        <= lat_b_d;
      lat_op_q       <= lat_op_d;
      rsp_result_q   <= rsp_result_d;
      rsp_flags_q    <= rsp_flags_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_flags    = rsp_flags_q;
  assign bus.rsp_mismatch = rsp_mismatch_q;
  assign mismatch_count   = cnt_q;

endmodule

// File: tb/tb_alu_16bit_issuer.sv
// Directed bench for alu_16bit_issuer: the bench plays the ALU, driving hand-picked
// result/flag values, and checks capture, mismatch detection, back-pressure and reset abort.
module tb_alu_16bit_issuer;
  import alu_16bit_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] mismatch_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_16bit_issuer_if bus ();

  alu_16bit_issuer #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cnt_clr        (cnt_clr),
    .bus            (bus),
    .mismatch_count (mismatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ALU stub: flags given as {carry, zero, overflow, negative}
  task automatic set_alu(input logic [15:0] res, input logic [3:0] fl);
    bus.alu_result   = res;
    bus.alu_carry    = fl[3];
    bus.alu_zero     = fl[2];
    bus.alu_overflow = fl[1];
    bus.alu_negative = fl[0];
  endtask

  // Accept edge, EXEC->SAMPLE edge, SAMPLE->RESP edge; returns sitting in RESP
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic clr);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    cnt_clr = clr;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 16'h0;
    bus.cmd_b     = 16'h0;
    bus.cmd_op    = OP_ADD;
    bus.rsp_ready = 1'b0;
    set_alu(16'h0, 4'b0000);
    tick();
    tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'h0);
    check("rst_alu_op", 32'(bus.alu_op), 32'h0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    check("rst_mismatch", 32'(bus.rsp_mismatch), 32'h0);
    check("rst_count", 32'(mismatch_count), 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // ADD 0x7FFF+0x0001 -> 0x8000, overflow and negative
    set_alu(16'h8000, 4'b0011);
    bus.cmd_a = 16'h7FFF; bus.cmd_b = 16'h0001; bus.cmd_op = OP_ADD;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("add_alu_a", 32'(bus.alu_a), 32'h7FFF);
    check("add_alu_b", 32'(bus.alu_b), 32'h0001);
    check("add_busy_ready", 32'(bus.cmd_ready), 32'd0);
    check("add_valid_e0", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("add_valid_e1", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("add_valid_e2", 32'(bus.rsp_valid), 32'd1);
    check("add_result", 32'(bus.rsp_result), 32'h8000);
    check("add_flags", 32'(bus.rsp_flags), 32'b0011);
    check("add_mismatch", 32'(bus.rsp_mismatch), 32'd0);
    check("add_count", 32'(mismatch_count), 32'd0);
    drain();
    check("add_back_idle", 32'(bus.cmd_ready), 32'd1);
    check("add_valid_drop", 32'(bus.rsp_valid), 32'd0);

    // SUB 0x0000-0x0001 -> 0xFFFF, carry and negative
    set_alu(16'hFFFF, 4'b1001);
    issue(16'h0000, 16'h0001, OP_SUB, 1'b0);
    check("sub_result", 32'(bus.rsp_result), 32'hFFFF);
    check("sub_flags", 32'(bus.rsp_flags), 32'b1001);
    check("sub_mismatch", 32'(bus.rsp_mismatch), 32'd0);
    drain();

    // AND 0xF0F0&0x0FF0 is 0x00F0; stub returns 0x00F1
    set_alu(16'h00F1, 4'b0000);
    issue(16'hF0F0, 16'h0FF0, OP_AND, 1'b0);
    check("and_mismatch", 32'(bus.rsp_mismatch), 32'd1);
    check("and_count", 32'(mismatch_count), 32'd1);
    drain();
    issue(16'hF0F0, 16'h0FF0, OP_AND, 1'b1);
    check("clr_mismatch", 32'(bus.rsp_mismatch), 32'd1);
    check("clr_count", 32'(mismatch_count), 32'd0);
    drain();

    // OR 0x1200|0x0034 = 0x1234, correct stub
    set_alu(16'h1234, 4'b0000);
    issue(16'h1200, 16'h0034, OP_OR, 1'b0);
    check("or_result", 32'(bus.rsp_result), 32'h1234);
    check("or_mismatch", 32'(bus.rsp_mismatch), 32'd0);
    drain();

    // ADD 0xFFFF+0x0001 -> 0x0000 with carry and zero
    set_alu(16'h0000, 4'b1100);
    issue(16'hFFFF, 16'h0001, OP_ADD, 1'b0);
    check("addc_flags", 32'(bus.rsp_flags), 32'b1100);
    check("addc_mismatch", 32'(bus.rsp_mismatch), 32'd0);
    drain();

    // ADD 1+1 = 2: right result, wrong carry flag
    set_alu(16'h0002, 4'b1000);
    issue(16'h0001, 16'h0001, OP_ADD, 1'b0);
    check("flag_mismatch", 32'(bus.rsp_mismatch), 32'd1);
    check("flag_count", 32'(mismatch_count), 32'd1);
    drain();

    // Back-pressure: hold rsp_ready low with a new command pending
    set_alu(16'h0003, 4'b0000);
    issue(16'h0001, 16'h0002, OP_ADD, 1'b0);
    bus.cmd_a = 16'h5555; bus.cmd_b = 16'h0000; bus.cmd_op = OP_ADD;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_ready", 32'(bus.cmd_ready), 32'd0);
      check("hold_result", 32'(bus.rsp_result), 32'h0003);
      check("hold_mismatch", 32'(bus.rsp_mismatch), 32'd0);
      check("hold_alu_a", 32'(bus.alu_a), 32'h0001);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("release_idle", 32'(bus.cmd_ready), 32'd1);
    set_alu(16'h5555, 4'b0000);
    tick();
    bus.cmd_valid = 1'b0;
    check("next_accept_a", 32'(bus.alu_a), 32'h5555);
    check("next_accept_busy", 32'(bus.cmd_ready), 32'd0);
    tick();
    tick();
    check("next_valid", 32'(bus.rsp_valid), 32'd1);
    check("next_result", 32'(bus.rsp_result), 32'h5555);
    check("next_count", 32'(mismatch_count), 32'd1);
    drain();

    // Reset during SAMPLE with a mismatching stub aborts the operation
    set_alu(16'hDEAD, 4'b0000);
    bus.cmd_a = 16'h00A0; bus.cmd_b = 16'h000B; bus.cmd_op = OP_OR;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready_low", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("abort_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_count", 32'(mismatch_count), 32'd0);
    check("abort_alu_a", 32'(bus.alu_a), 32'h0);
    check("abort_alu_b", 32'(bus.alu_b), 32'h0);
    check("abort_alu_op", 32'(bus.alu_op), 32'h0);
    rst_n = 1'b1;
    #1;
    check("abort_ready_after", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("abort_count_after", 32'(mismatch_count), 32'd0);

    // Saturation: 16 mismatches into a 4-bit counter
    set_alu(16'h00F1, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      issue(16'hF0F0, 16'h0FF0, OP_AND, 1'b0);
      check("sat_count", 32'(mismatch_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      drain();
    end
    check("sat_final", 32'(mismatch_count), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
